// File: rtl/seven_seg_display_scheduler_if.sv
// Requester/display bundle for the seven-segment display scheduler.
// The master drives requests and content; the slave (scheduler) returns grant and display data.
interface seven_seg_display_scheduler_if #(
  parameter int unsigned SEVEN_SEGMENT_COUNT = 8,
  parameter int unsigned REQUESTER_COUNT     = 4
);
  logic [REQUESTER_COUNT-1:0]                       req_in;
  logic [REQUESTER_COUNT*SEVEN_SEGMENT_COUNT*4-1:0] value_in;
  logic [REQUESTER_COUNT*SEVEN_SEGMENT_COUNT-1:0]   mask_in;
  logic [REQUESTER_COUNT-1:0]                       grant_out;
  logic                                             done_out;
  logic                                             scan_clke_out;
  logic [SEVEN_SEGMENT_COUNT*4-1:0]                 disp_value_out;
  logic [SEVEN_SEGMENT_COUNT-1:0]                   disp_mask_out;

  modport master (
    output req_in, value_in, mask_in,
    input  grant_out, done_out, scan_clke_out, disp_value_out, disp_mask_out
  );

  modport slave (
    input  req_in, value_in, mask_in,
    output grant_out, done_out, scan_clke_out, disp_value_out, disp_mask_out
  );
endinterface

// File: rtl/seven_seg_display_scheduler.sv
// Round-robin time-sharing of an eight-digit seven-segment display between requesters,
// plus the digit-scan strobe. Each grant holds a frozen snapshot for HOLD_FRAMES frames.
module seven_seg_display_scheduler #(
  parameter int unsigned SEVEN_SEGMENT_COUNT = 8,
  parameter int unsigned REQUESTER_COUNT     = 4,
  parameter int unsigned SCAN_DIVIDER        = 50000,
  parameter int unsigned HOLD_FRAMES         = 16
) (
  input logic                         clk_in,
  input logic                         rst_in,
  seven_seg_display_scheduler_if.slave bus
);

  localparam int unsigned ValueW = SEVEN_SEGMENT_COUNT * 4;
  localparam int unsigned PresW  = $clog2(SCAN_DIVIDER);
  localparam int unsigned DigW   = (SEVEN_SEGMENT_COUNT > 1) ? $clog2(SEVEN_SEGMENT_COUNT) : 1;
  localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned IdxW   = $clog2(REQUESTER_COUNT);

  typedef enum logic [1:0] {StIdle, StShow, StRelease} state_e;

  state_e                     state_q, state_d;
  logic [PresW-1:0]           presc_q;
  logic [DigW-1:0]            digit_q;
  logic [HoldW-1:0]           hold_q, hold_d;
  logic [IdxW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]            winner_q, winner_d;
  logic [REQUESTER_COUNT-1:0] grant_q, grant_d;
  logic                       done_q, done_d;
  logic [ValueW-1:0]          disp_value_q, sel_value;
  logic [SEVEN_SEGMENT_COUNT-1:0] disp_mask_q, sel_mask;

  logic            strobe, frame_end, found, latch_en;
  logic [IdxW-1:0] winner, cand;

  assign strobe    = (presc_q == PresW'(SCAN_DIVIDER - 1));
  assign frame_end = strobe && (digit_q == DigW'(SEVEN_SEGMENT_COUNT - 1));

  // Free-running scan timing, independent of the grant state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= strobe ? '0 : presc_q + 1'b1;
      if (strobe) begin
        digit_q <= (digit_q == DigW'(SEVEN_SEGMENT_COUNT - 1)) ? '0 : digit_q + 1'b1;
      end
    end
  end

  // Round-robin search upward from rr_ptr_q with wrap.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < REQUESTER_COUNT; i++) begin
      if (int'(rr_ptr_q) + i >= REQUESTER_COUNT) begin
        cand = IdxW'(int'(rr_ptr_q) + i - REQUESTER_COUNT);
      end else begin
        cand = IdxW'(int'(rr_ptr_q) + i);
      end
      if (!found && bus.req_in[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    sel_value = bus.value_in[winner * ValueW +: ValueW];
    sel_mask  = bus.mask_in[winner * SEVEN_SEGMENT_COUNT +: SEVEN_SEGMENT_COUNT];
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rr_ptr_d = rr_ptr_q;
    winner_d = winner_q;
    grant_d  = grant_q;
    done_d   = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d         = StShow;
          winner_d        = winner;
          hold_d          = '0;
          latch_en        = 1'b1;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
        end
      end
      StShow: begin
        if (frame_end) begin
          hold_d = hold_q + 1'b1;
        end
        // Early release wins over a simultaneous hold expiry; both end the same way.
        if (!bus.req_in[winner_q] ||
            (frame_end && hold_q == HoldW'(HOLD_FRAMES - 1))) begin
          state_d = StRelease;
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
      StRelease: begin
        state_d  = StIdle;
        rr_ptr_d = (winner_q == IdxW'(REQUESTER_COUNT - 1)) ? '0 : winner_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      grant_q      <= '0;
      done_q       <= 1'b0;
      disp_value_q <= '0;
      disp_mask_q  <= '1;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      if (latch_en) begin
        disp_value_q <= sel_value;
        disp_mask_q  <= sel_mask;
      end
    end
  end

  assign bus.grant_out      = grant_q;
  assign bus.done_out       = done_q;
  assign bus.scan_clke_out  = strobe;
  assign bus.disp_value_out = disp_value_q;
  assign bus.disp_mask_out  = disp_mask_q;

endmodule
